// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// FSM state encoding, instruction classes and IR field slices.
package cpu_defs;

   localparam int NREGS  = 16;
   localparam int OPW    = 5;
   localparam int RIDX_W = $clog2(NREGS);

   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
   localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
   localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
   localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPW-1:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SHR  = 4'b0010;
   localparam logic [3:0] ALU_SHRA = 4'b0011;
   localparam logic [3:0] ALU_SHL  = 4'b0100;
   localparam logic [3:0] ALU_ROR  = 4'b0101;
   localparam logic [3:0] ALU_ROL  = 4'b0110;
   localparam logic [3:0] ALU_MUL  = 4'b0111;
   localparam logic [3:0] ALU_DIV  = 4'b1000;
   localparam logic [3:0] ALU_NEG  = 4'b1001;
   localparam logic [3:0] ALU_AND  = 4'b1010;
   localparam logic [3:0] ALU_OR   = 4'b1011;
   localparam logic [3:0] ALU_NOT  = 4'b1100;

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      K_BIN, K_IMM, K_UNARY, K_MULDIV, K_NOP, K_HALT, K_ILLEGAL
   } iclass_t;

   // Single-bit strobes and ALU code, grouped so clear can gate them in one place.
   typedef struct packed {
      logic       pc_out, zlow_out, zhigh_out, hi_out, lo_out, mdr_out, c_out;
      logic       mar_in, pc_in, mdr_in, ir_in, y_in, inc_pc, read;
      logic       zlow_in, zhigh_in, hi_in, lo_in;
      logic       run, illegal;
      logic [3:0] operation;
   } ctrl_t;

   function automatic logic [OPW-1:0] ir_op(input logic [31:0] ir);
      return ir[31:27];
   endfunction

   function automatic logic [RIDX_W-1:0] ir_ra(input logic [31:0] ir);
      return ir[26:23];
   endfunction

   function automatic logic [RIDX_W-1:0] ir_rb(input logic [31:0] ir);
      return ir[22:19];
   endfunction

   function automatic logic [RIDX_W-1:0] ir_rc(input logic [31:0] ir);
      return ir[18:15];
   endfunction

   function automatic iclass_t op_class(input logic [OPW-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:   return K_BIN;
         OP_ADDI, OP_ANDI, OP_ORI:          return K_IMM;
         OP_NEG, OP_NOT:                    return K_UNARY;
         OP_MUL, OP_DIV:                    return K_MULDIV;
         OP_NOP:                            return K_NOP;
         OP_HALT:                           return K_HALT;
         default:                           return K_ILLEGAL;
      endcase
   endfunction

   function automatic logic [3:0] alu_code(input logic [OPW-1:0] op);
      case (op)
         OP_ADD, OP_ADDI: return ALU_ADD;
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR, OP_ORI:   return ALU_OR;
         OP_ROR:          return ALU_ROR;
         OP_ROL:          return ALU_ROL;
         OP_SHR:          return ALU_SHR;
         OP_SHRA:         return ALU_SHRA;
         OP_SHL:          return ALU_SHL;
         OP_MUL:          return ALU_MUL;
         OP_DIV:          return ALU_DIV;
         OP_NEG:          return ALU_NEG;
         OP_NOT:          return ALU_NOT;
         default:         return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register index + enable to one-hot select; purely combinational, zero latency.
// No backpressure: output follows inputs every cycle.
module reg_select_decoder
   import cpu_defs::*;
(
   input  logic [RIDX_W-1:0] index,
   input  logic              enable,
   output logic [NREGS-1:0]  onehot
);

   always_comb begin
      onehot = '0;
      if (enable) onehot[index] = 1'b1;
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch, decode IR, one datapath step per Clock.
// Latency binary/imm 6, unary 5, mul/div 7, nop 4 cycles; no backpressure, Stop halts at T0.
module control_unit
   import cpu_defs::*;
(
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        Stop,
   output logic        PCout,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        HIout,
   output logic        LOout,
   output logic        MDRout,
   output logic        Cout,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        IncPC,
   output logic        Read,
   output logic        Zin_low,
   output logic        Zin_high,
   output logic        HIin,
   output logic        LOin,
   output logic [15:0] Rout_sel,
   output logic [15:0] Rin_sel,
   output logic [3:0]  operation,
   output logic        Run,
   output logic        Illegal
);

   state_t            state, next_state;
   ctrl_t             ctrl, ctrl_g;
   iclass_t           kind;
   logic [3:0]        alu_op;
   logic [RIDX_W-1:0] rout_idx, rin_idx;
   logic              rout_en, rin_en;
   logic              ir_unused_bits;

   assign kind           = op_class(ir_op(IR));
   assign alu_op         = alu_code(ir_op(IR));
   assign ir_unused_bits = ^IR[14:0];

   always_ff @(posedge Clock) begin
      if (clear) state <= S_RST;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      ctrl       = '0;
      ctrl.run   = (state != S_HALT);
      rout_idx   = '0;
      rout_en    = 1'b0;
      rin_idx    = '0;
      rin_en     = 1'b0;
      case (state)
         S_RST: next_state = S_T0;
         S_T0: begin
            ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.zlow_in = 1'b1;
            next_state  = Stop ? S_HALT : S_T1;
         end
         S_T1: begin
            ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            next_state    = S_T2;
         end
         S_T2: begin
            ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            next_state   = S_T3;
         end
         S_T3: begin
            next_state = S_T0;
            case (kind)
               K_BIN, K_IMM: begin
                  rout_idx = ir_rb(IR); rout_en = 1'b1; ctrl.y_in = 1'b1;
                  next_state = S_T4;
               end
               K_UNARY: begin
                  rout_idx = ir_rb(IR); rout_en = 1'b1;
                  ctrl.operation = alu_op; ctrl.zlow_in = 1'b1;
                  next_state = S_T4;
               end
               K_MULDIV: begin
                  rout_idx = ir_ra(IR); rout_en = 1'b1; ctrl.y_in = 1'b1;
                  next_state = S_T4;
               end
               K_HALT:    next_state = S_HALT;
               K_ILLEGAL: ctrl.illegal = 1'b1;
               default:   next_state = S_T0;
            endcase
         end
         S_T4: begin
            next_state = S_T5;
            case (kind)
               K_BIN: begin
                  rout_idx = ir_rc(IR); rout_en = 1'b1;
                  ctrl.operation = alu_op; ctrl.zlow_in = 1'b1;
               end
               K_IMM: begin
                  ctrl.c_out = 1'b1; ctrl.operation = alu_op; ctrl.zlow_in = 1'b1;
               end
               K_UNARY: begin
                  ctrl.zlow_out = 1'b1; rin_idx = ir_ra(IR); rin_en = 1'b1;
                  next_state = S_T0;
               end
               K_MULDIV: begin
                  rout_idx = ir_rb(IR); rout_en = 1'b1; ctrl.operation = alu_op;
                  ctrl.zlow_in = 1'b1; ctrl.zhigh_in = 1'b1;
               end
               default: next_state = S_T0;
            endcase
         end
         S_T5: begin
            ctrl.zlow_out = 1'b1;
            if (kind == K_MULDIV) begin
               ctrl.lo_in = 1'b1;
               next_state = S_T6;
            end else begin
               rin_idx = ir_ra(IR); rin_en = 1'b1;
               next_state = S_T0;
            end
         end
         S_T6: begin
            ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
            next_state = S_T0;
         end
         S_HALT:  next_state = S_HALT;
         default: next_state = S_RST;
      endcase
   end

   // clear forces every output low combinationally, so the abandoned cycle writes nothing.
   assign ctrl_g = clear ? '0 : ctrl;

   assign PCout     = ctrl_g.pc_out;
   assign Zlowout   = ctrl_g.zlow_out;
   assign Zhighout  = ctrl_g.zhigh_out;
   assign HIout     = ctrl_g.hi_out;
   assign LOout     = ctrl_g.lo_out;
   assign MDRout    = ctrl_g.mdr_out;
   assign Cout      = ctrl_g.c_out;
   assign MARin     = ctrl_g.mar_in;
   assign PCin      = ctrl_g.pc_in;
   assign MDRin     = ctrl_g.mdr_in;
   assign IRin      = ctrl_g.ir_in;
   assign Yin       = ctrl_g.y_in;
   assign IncPC     = ctrl_g.inc_pc;
   assign Read      = ctrl_g.read;
   assign Zin_low   = ctrl_g.zlow_in;
   assign Zin_high  = ctrl_g.zhigh_in;
   assign HIin      = ctrl_g.hi_in;
   assign LOin      = ctrl_g.lo_in;
   assign operation = ctrl_g.operation;
   assign Run       = ctrl_g.run;
   assign Illegal   = ctrl_g.illegal;

   reg_select_decoder u_rout_dec (
      .index  (rout_idx),
      .enable (rout_en & ~clear),
      .onehot (Rout_sel)
   );

   reg_select_decoder u_rin_dec (
      .index  (rin_idx),
      .enable (rin_en & ~clear),
      .onehot (Rin_sel)
   );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instructions plus random IR/Stop/clear
// against a per-instruction list of expected cycle outputs.
module tb_control_unit;

   typedef struct packed {
      logic        pcout, zlowout, zhighout, hiout, loout, mdrout, cout;
      logic        marin, pcin, mdrin, irin, yin, incpc, read;
      logic        zin_low, zin_high, hiin, loin;
      logic [15:0] rout, rin;
      logic [3:0]  op;
      logic        run, illegal;
   } out_t;

   logic        Clock = 1'b0;
   logic        clear = 1'b1;
   logic        Stop  = 1'b0;
   logic [31:0] IR    = 32'h0;
   logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout;
   logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
   logic        Zin_low, Zin_high, HIin, LOin, Run, Illegal;
   logic [15:0] Rout_sel, Rin_sel;
   logic [3:0]  operation;

   int   checks   = 0;
   int   failures = 0;
   out_t obs;
   out_t trace[$];

   control_unit dut (
      .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout),
      .LOout(LOout), .MDRout(MDRout), .Cout(Cout), .MARin(MARin), .PCin(PCin),
      .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
      .Zin_low(Zin_low), .Zin_high(Zin_high), .HIin(HIin), .LOin(LOin),
      .Rout_sel(Rout_sel), .Rin_sel(Rin_sel), .operation(operation),
      .Run(Run), .Illegal(Illegal)
   );

   always #5 Clock = ~Clock;

   always_comb begin
      obs          = '0;
      obs.pcout    = PCout;    obs.zlowout  = Zlowout;  obs.zhighout = Zhighout;
      obs.hiout    = HIout;    obs.loout    = LOout;    obs.mdrout   = MDRout;
      obs.cout     = Cout;     obs.marin    = MARin;    obs.pcin     = PCin;
      obs.mdrin    = MDRin;    obs.irin     = IRin;     obs.yin      = Yin;
      obs.incpc    = IncPC;    obs.read     = Read;     obs.zin_low  = Zin_low;
      obs.zin_high = Zin_high; obs.hiin     = HIin;     obs.loin     = LOin;
      obs.rout     = Rout_sel; obs.rin      = Rin_sel;  obs.op       = operation;
      obs.run      = Run;      obs.illegal  = Illegal;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic string kind_of(input logic [4:0] op);
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: return "bin";
         5'd12, 5'd13, 5'd14: return "imm";
         5'd15, 5'd16:        return "md";
         5'd17, 5'd18:        return "un";
         5'd26:               return "nop";
         5'd27:               return "halt";
         default:             return "ill";
      endcase
   endfunction

   function automatic logic [3:0] alu_of(input logic [4:0] op);
      case (op)
         5'd3, 5'd12: return 4'd0;
         5'd4:        return 4'd1;
         5'd5, 5'd13: return 4'd10;
         5'd6, 5'd14: return 4'd11;
         5'd7:        return 4'd5;
         5'd8:        return 4'd6;
         5'd9:        return 4'd2;
         5'd10:       return 4'd3;
         5'd11:       return 4'd4;
         5'd15:       return 4'd7;
         5'd16:       return 4'd8;
         5'd17:       return 4'd9;
         5'd18:       return 4'd12;
         default:     return 4'd0;
      endcase
   endfunction

   function automatic out_t blank();
      out_t e = '0;
      e.run = 1'b1;
      return e;
   endfunction

   function automatic logic [15:0] sel(input logic [3:0] r);
      logic [15:0] one = 16'h0001;
      return one << r;
   endfunction

   // Expected outputs, one entry per cycle, for a whole instruction starting at fetch.
   task automatic model(input logic [31:0] ir, input bit stop, output out_t q[$], output bit halts);
      out_t        e;
      string       k  = kind_of(ir[31:27]);
      logic [3:0]  a  = alu_of(ir[31:27]);
      logic [3:0]  ra = ir[26:23];
      logic [3:0]  rb = ir[22:19];
      logic [3:0]  rc = ir[18:15];
      q = {};
      e = blank(); e.pcout = 1; e.marin = 1; e.incpc = 1; e.zin_low = 1; q.push_back(e);
      halts = stop;
      if (stop) return;
      e = blank(); e.zlowout = 1; e.pcin = 1; e.read = 1; e.mdrin = 1; q.push_back(e);
      e = blank(); e.mdrout = 1; e.irin = 1; q.push_back(e);
      if (k == "bin" || k == "imm") begin
         e = blank(); e.rout = sel(rb); e.yin = 1; q.push_back(e);
         e = blank(); e.op = a; e.zin_low = 1;
         if (k == "bin") e.rout = sel(rc); else e.cout = 1;
         q.push_back(e);
         e = blank(); e.zlowout = 1; e.rin = sel(ra); q.push_back(e);
      end else if (k == "un") begin
         e = blank(); e.rout = sel(rb); e.op = a; e.zin_low = 1; q.push_back(e);
         e = blank(); e.zlowout = 1; e.rin = sel(ra); q.push_back(e);
      end else if (k == "md") begin
         e = blank(); e.rout = sel(ra); e.yin = 1; q.push_back(e);
         e = blank(); e.rout = sel(rb); e.op = a; e.zin_low = 1; e.zin_high = 1; q.push_back(e);
         e = blank(); e.zlowout = 1; e.loin = 1; q.push_back(e);
         e = blank(); e.zhighout = 1; e.hiin = 1; q.push_back(e);
      end else begin
         e = blank(); e.illegal = (k == "ill"); q.push_back(e);
         halts = (k == "halt");
      end
   endtask

   // Entered and left at a negedge with the DUT in T0; a clear at cycle abort_at abandons it.
   task automatic run_instr(input logic [31:0] ir, input bit stop, input int abort_at,
                            output bit halted);
      out_t q[$];
      bit   h;
      model(ir, stop, q, h);
      trace = {};
      IR    = ir;
      halted = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         Stop = (i == 0) ? stop : 1'b0;
         if (i == abort_at) begin
            clear = 1'b1;
            #1 check($sformatf("abort_c%0d_ir%h", i, ir), 64'(obs), 64'(0));
            @(posedge Clock); @(negedge Clock);
            clear = 1'b0;
            #1 check("abort_rst", 64'(obs), 64'(blank()));
            @(posedge Clock); @(negedge Clock);
            return;
         end
         #1;
         trace.push_back(obs);
         check($sformatf("%s_c%0d_ir%h", kind_of(ir[31:27]), i, ir), 64'(obs), 64'(q[i]));
         @(posedge Clock); @(negedge Clock);
      end
      Stop   = 1'b0;
      halted = h;
   endtask

   task automatic hold_halt_and_recover(input int n);
      for (int i = 0; i < n; i++) begin
         #1 check($sformatf("halt_c%0d", i), 64'(obs), 64'(0));
         @(posedge Clock); @(negedge Clock);
      end
      clear = 1'b1;
      #1 check("halt_clear", 64'(obs), 64'(0));
      @(posedge Clock); @(negedge Clock);
      clear = 1'b0;
      #1 check("halt_rst", 64'(obs), 64'(blank()));
      @(posedge Clock); @(negedge Clock);
   endtask

   initial begin
      bit         h;
      logic [4:0] op;
      int         ab;
      bit         st;
      out_t       t0;

      @(negedge Clock);
      #1 check("clear_c0", 64'(obs), 64'(0));
      @(posedge Clock); @(negedge Clock);
      #1 check("clear_c1", 64'(obs), 64'(0));
      clear = 1'b0;
      #1 check("rst_state", 64'(obs), 64'(blank()));
      @(posedge Clock); @(negedge Clock);
      t0 = blank(); t0.pcout = 1; t0.marin = 1; t0.incpc = 1; t0.zin_low = 1;
      #1 check("first_t0", 64'(obs), 64'(t0));

      run_instr(32'h28918000, 1'b0, -1, h);
      check("and_t3_rout", 64'(trace[3].rout), 64'h0004);
      check("and_t4_op",   64'(trace[4].op),   64'hA);
      check("and_t5_rin",  64'(trace[5].rin),  64'h0002);

      run_instr(32'h7A280000, 1'b0, -1, h);
      check("mul_t4_rout", 64'(trace[4].rout), 64'h0020);
      check("mul_len",     64'(trace.size()),  64'd7);
      for (int i = 0; i < 7; i++) check($sformatf("mul_rin_c%0d", i), 64'(trace[i].rin), 64'h0);

      run_instr(32'h610FFFFB, 1'b0, -1, h);
      check("addi_t4_cout", 64'(trace[4].cout), 64'h1);
      check("addi_t5_rin",  64'(trace[5].rin),  64'h0004);

      run_instr(32'h8B380000, 1'b0, -1, h);
      check("neg_t3_rout", 64'(trace[3].rout), 64'h0080);
      check("neg_t4_rin",  64'(trace[4].rin),  64'h0040);

      run_instr(32'hD0000000, 1'b0, -1, h);
      run_instr(32'hF8000000, 1'b0, -1, h);
      check("ill_t3", 64'(trace[3].illegal), 64'h1);
      check("ill_t2", 64'(trace[2].illegal), 64'h0);

      run_instr(32'h28918000, 1'b0, 4, h);

      run_instr(32'hD8000000, 1'b0, -1, h);
      check("halt_flag", 64'(h), 64'h1);
      hold_halt_and_recover(10);

      run_instr(32'h28918000, 1'b1, -1, h);
      hold_halt_and_recover(3);

      for (int n = 0; n < 80; n++) begin
         op = 5'($urandom_range(0, 31));
         st = ($urandom_range(0, 9) == 0);
         ab = (!st && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : -1;
         run_instr({op, 27'($urandom)}, st, ab, h);
         if (h) hold_halt_and_recover(int'($urandom_range(1, 4)));
      end

      run_instr(32'hD0000000, 1'b0, -1, h);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
